divider_seq: RTL and testbench
==============================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter DIVIDEND_W, default 16, meaning dividend and quotient width.
REQ-002 The block SHALL have parameter DIVISOR_W, default 8, meaning divisor and remainder width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The port list SHALL be, in this order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a division.
- op_a  input  DIVIDEND_W  dividend, sampled only when start is accepted.
- op_b  input  DIVISOR_W  divisor, sampled only when start is accepted.
- busy  output  1  division in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_zero  output  1  flag: the last accepted op_b was zero.

Function
REQ-005 All operands and results SHALL be unsigned. For every op_b not equal to 0, op_a SHALL equal quotient*op_b+remainder, with remainder less than op_b.
REQ-006 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-007 start SHALL be accepted in IDLE or DONE: op_a and op_b are captured on that edge, and the next state is CALC (op_b not 0) or DONE (op_b = 0).
REQ-008 CALC SHALL perform one radix-2 restoring step per cycle, MSB first, for exactly DIVIDEND_W cycles, then go to DONE.
REQ-009 Latency for a non-zero divisor SHALL be DIVIDEND_W+1 cycles from the start edge to done=1 (17 cycles at default widths).
REQ-010 Latency for a zero divisor SHALL be 1 cycle from the start edge to done=1.
REQ-011 The partial remainder register SHALL be DIVISOR_W+1 bits wide, so the trial subtraction never loses the carry.
REQ-012 busy SHALL be 1 exactly while the state is CALC.
REQ-013 done SHALL be 1 exactly while the state is DONE, for a single cycle; DONE SHALL return to IDLE unless start is asserted.
REQ-014 quotient, remainder and div_zero SHALL change only on the cycle done rises, and SHALL hold until the next done.
REQ-015 On a zero divisor the outputs SHALL be: quotient = all ones, remainder = op_a[DIVISOR_W-1:0], div_zero = 1.
REQ-016 On a non-zero divisor, div_zero SHALL be 0.
REQ-017 start during CALC SHALL be ignored, with no effect on the operation in progress and no captured operands.
REQ-018 start in DONE SHALL begin a new operation back-to-back; done still pulses for the finished result.
REQ-019 op_a and op_b SHALL have no effect except on the start-acceptance edge.

Reset
REQ-020 rst_n low SHALL, asynchronously, force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, and clear all internal registers.
REQ-021 Reset asserted during CALC SHALL abort the operation with no done pulse.
REQ-022 The first start after reset release SHALL be accepted on the first rising edge at which rst_n is high.

Structure
REQ-023 Package divider_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the default width constants.
REQ-024 One sub-module, div_step, SHALL implement a combinational single restoring step: shift in the dividend bit, trial-subtract, select, and emit the quotient bit.
REQ-025 divider_seq SHALL instantiate exactly one div_step and SHALL contain the FSM, iteration counter and result registers.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- op_a=6, op_b=3, start -> done at cycle 17, quotient=2, remainder=0, div_zero=0.
- op_a=24, op_b=6 -> quotient=4, remainder=0. op_a=100, op_b=7 -> quotient=14, remainder=2.
- op_a=65535, op_b=1 -> quotient=65535, remainder=0. op_a=5, op_b=255 -> quotient=0, remainder=5.
- op_a=9, op_b=0 -> done 1 cycle after start, quotient=16'hFFFF, remainder=9, div_zero=1.
- op_a=100, op_b=7 started, then start with op_a=1, op_b=1 at cycle 5 -> still quotient=14, remainder=2, one done pulse; a start in the DONE cycle -> second result 17 cycles later.
- rst_n low at cycle 8 of CALC -> all outputs 0, no done; after release, op_a=9, op_b=3 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

    localparam int DEFAULT_DIVIDEND_W = 16;
    localparam int DEFAULT_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_seq_div_step.sv
// One combinational radix-2 restoring division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 quot_bit
);

    localparam int REM_W = DIVISOR_W + 1;

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] divisor_ext;

    // The shifted value is kept one bit wider than the remainder register so
    // the comparison sees every bit, including any carry out of the shift.
    always_comb begin
        shifted     = {rem_in, dividend_bit};
        divisor_ext = {2'b00, divisor};
        quot_bit    = (shifted >= divisor_ext);
        rem_out     = REM_W'(quot_bit ? (shifted - divisor_ext) : shifted);
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned divider: one restoring step per cycle, MSB first,
// with registered busy/done handshake and results held until the next done.
module divider_seq
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
    parameter int DIVISOR_W  = DEFAULT_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] op_a,
    input  logic [DIVISOR_W-1:0]  op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [DIVIDEND_W-1:0] dividend_q,  dividend_d;
    logic [DIVISOR_W-1:0]  divisor_q,   divisor_d;
    logic [DIVISOR_W:0]    rem_q,       rem_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  div_zero_q,  div_zero_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dividend_q[DIVIDEND_W-1]),
        .divisor      (divisor_q),
        .rem_out      (step_rem),
        .quot_bit     (step_q_bit)
    );

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path through
        // the case statement leaves it unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            CALC: begin
                // The dividend register doubles as the quotient shift register.
                rem_d      = step_rem;
                dividend_d = {dividend_q[DIVIDEND_W-2:0], step_q_bit};
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = {dividend_q[DIVIDEND_W-2:0], step_q_bit};
                    remainder_d = step_rem[DIVISOR_W-1:0];
                    div_zero_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                state_d = IDLE;
                if (start) begin
                    dividend_d = op_a;
                    divisor_d  = op_b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    if (op_b == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = op_a[DIVISOR_W-1:0];
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: a scoreboard queue of expected results
// is filled as starts are accepted and drained whenever done pulses.
module tb_divider_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   done_cnt;
    int   n_checks;
    int   n_fail;

    divider_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    // Caller is at a negedge; start is held across one rising edge.
    task automatic issue_now(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        if (b == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.z   = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = a / {8'd0, b};
            e.r   = 8'(a % {8'd0, b});
            e.z   = 1'b0;
            e.lat = 17;
        end
        e.cyc = cyc;
        sb.push_back(e);
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 8'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", sb.size(), 0);
    endtask

    // Scoreboard consumer: one pop per done pulse, results and latency compared.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check("busy_with_done", busy, 1'b0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_zero", div_zero, e.z);
                check("latency", cyc - e.cyc + 1, e.lat);
            end
        end
    end

    initial begin
        int dc;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cyc      = 0;
        done_cnt = 0;
        n_checks = 0;
        n_fail   = 0;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 16'd0);
        check("rst_remainder", remainder, 8'd0);
        check("rst_div_zero", div_zero, 1'b0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic case with busy observed during the operation.
        @(negedge clk);
        issue_now(16'd6, 8'd3);
        @(negedge clk);
        check("busy_in_calc", busy, 1'b1);
        check("no_early_done", done, 1'b0);
        wait_drain();

        // Directed operand table.
        @(negedge clk); issue_now(16'd24, 8'd6);     wait_drain();
        @(negedge clk); issue_now(16'd100, 8'd7);    wait_drain();
        @(negedge clk); issue_now(16'd65535, 8'd1);  wait_drain();
        @(negedge clk); issue_now(16'd5, 8'd255);    wait_drain();
        @(negedge clk); issue_now(16'd9, 8'd0);      wait_drain();

        // Results must hold across idle cycles.
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 16'hFFFF);
        check("hold_remainder", remainder, 8'd9);
        check("hold_div_zero", div_zero, 1'b1);

        // Start during CALC is ignored; start in DONE runs back-to-back.
        dc = done_cnt;
        @(negedge clk);
        issue_now(16'd100, 8'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op_a  = 16'd1;
        op_b  = 8'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("first_done_seen", done, 1'b1);
        issue_now(16'd1000, 8'd13);
        wait_drain();
        check("b2b_done_count", done_cnt - dc, 2);

        // Reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        issue_now(16'd100, 8'd7);
        repeat (7) @(negedge clk);
        dc = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_quotient", quotient, 16'd0);
        check("abort_remainder", remainder, 8'd0);
        check("abort_div_zero", div_zero, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, dc);

        // First start after release is taken on the first rising edge.
        rst_n = 1'b1;
        issue_now(16'd9, 8'd3);
        wait_drain();

        // A few random operands, divisor zero included occasionally.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue_now(16'($urandom), (k == 2) ? 8'd0 : 8'($urandom_range(1, 255)));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
